// File: rtl/i2c_master_byte_ctrl.sv
// Single-byte I2C master: START, {adr,rw}, ACK, one data byte, ACK/NACK, STOP.
// Optional SCL clock stretching: define I2C_CLOCK_STRETCH_EN.
module i2c_master_byte_ctrl #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] adr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    inout  wire        SCL,
    inout  wire        SDA
);
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

    localparam logic [15:0] QMAX = 16'(DIV - 1);

    state_t      state;
    logic [15:0] qcnt;
    logic [1:0]  q;
    logic [2:0]  bitcnt;
    logic [7:0]  tx, rx, data_l;
    logic        rw_l, scl_oe, sda_oe, scl_drv, sda_drv, hold, qtick;

    assign SCL = scl_oe ? 1'b0 : 1'bz;
    assign SDA = sda_oe ? 1'b0 : 1'bz;

`ifdef I2C_CLOCK_STRETCH_EN
    // Slave holding SCL low while we have released it freezes the timebase.
    assign hold = q[1] && !scl_oe && !SCL;
`else
    assign hold = 1'b0;
`endif

    assign qtick = busy && !hold && (qcnt == QMAX);

    // Line drive for the current quarter; 1 = pull low.
    always_comb begin
        scl_drv = 1'b0;
        sda_drv = 1'b0;
        case (state)
            START: begin
                sda_drv = q[1];
                scl_drv = (q == 2'd3);
            end
            ADDR: begin
                scl_drv = !q[1];
                sda_drv = !tx[7];
            end
            DATA: begin
                scl_drv = !q[1];
                sda_drv = !rw_l && !tx[7];
            end
            ACK1, ACK2: scl_drv = !q[1];
            STOP: begin
                scl_drv = (q == 2'd0);
                sda_drv = !q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            qcnt     <= '0;
            q        <= '0;
            bitcnt   <= '0;
            tx       <= '0;
            rx       <= '0;
            data_l   <= '0;
            rw_l     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            rd_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            done   <= 1'b0;
            scl_oe <= scl_drv;
            sda_oe <= sda_drv;
            if (busy && !hold)
                qcnt <= (qcnt == QMAX) ? '0 : qcnt + 16'd1;

            // The done cycle itself never accepts, so a held start lands one cycle later.
            if (state == IDLE) begin
                if (start && !done) begin
                    state    <= START;
                    busy     <= 1'b1;
                    nack_err <= 1'b0;
                    rw_l     <= rw;
                    tx       <= {adr, rw};
                    data_l   <= wr_data;
                    q        <= '0;
                    qcnt     <= '0;
                    bitcnt   <= 3'd7;
                end
            end else if (qtick) begin
                q <= q + 2'd1;
                case (state)
                    START: if (q == 2'd3) state <= ADDR;
                    ADDR: if (q == 2'd3) begin
                        tx     <= {tx[6:0], 1'b0};
                        bitcnt <= bitcnt - 3'd1;
                        if (bitcnt == 3'd0) state <= ACK1;
                    end
                    ACK1: begin
                        if (q == 2'd2 && SDA) nack_err <= 1'b1;
                        if (q == 2'd3) begin
                            state <= nack_err ? STOP : DATA;
                            tx    <= data_l;
                        end
                    end
                    DATA: begin
                        if (q == 2'd2) rx <= {rx[6:0], SDA};
                        if (q == 2'd3) begin
                            tx     <= {tx[6:0], 1'b0};
                            bitcnt <= bitcnt - 3'd1;
                            if (bitcnt == 3'd0) state <= ACK2;
                        end
                    end
                    ACK2: begin
                        if (q == 2'd2 && !rw_l && SDA) nack_err <= 1'b1;
                        if (q == 2'd3) begin
                            if (rw_l) rd_data <= rx;
                            state <= STOP;
                        end
                    end
                    STOP: if (q == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: behavioural IO-extender slave plus a scoreboard of expected transactions.
module tb_i2c_master_byte_ctrl;
    localparam int DIV = 4;
    localparam logic [6:0] SLV = 7'h27;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0] adr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       busy, done, nack_err;
    wire        scl, sda;
    pullup (scl);
    pullup (sda);

    logic slv_sda_low = 1'b0, slv_scl_low = 1'b0;
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;

    i2c_master_byte_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .adr(adr), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .done(done), .nack_err(nack_err), .SCL(scl), .SDA(sda)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: updates on negedge so it only moves SDA while SCL is low.
    logic       pscl = 1'b1, psda = 1'b1, slv_rw = 1'b0, mack = 1'b0, stretch_en = 1'b0;
    logic [7:0] sh = '0, io_out = 8'hFF;
    logic [6:0] last_adr = '0;
    int         phase = 0, cnt = 0, hold_cnt = 0;
    int         n_start = 0, n_stop = 0, n_rise = 0;

    always @(negedge clk) begin
        pscl <= scl;
        psda <= sda;
        if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) slv_scl_low <= 1'b0;
        end
        if (pscl && scl && psda && !sda) begin
            n_start     <= n_start + 1;
            phase       <= 1;
            cnt         <= -1;
            slv_sda_low <= 1'b0;
        end else if (pscl && scl && !psda && sda) begin
            n_stop      <= n_stop + 1;
            phase       <= 0;
            slv_sda_low <= 1'b0;
        end else if (!pscl && scl) begin
            n_rise <= n_rise + 1;
            if ((phase == 1 || phase == 2) && cnt >= 0 && cnt < 8) sh <= {sh[6:0], sda};
            if (phase == 3 && cnt == 8) mack <= sda;
        end else if (pscl && !scl) begin
            cnt <= cnt + 1;
            if (phase == 1 && cnt == 7) begin
                last_adr <= sh[7:1];
                if (sh[7:1] == SLV) begin
                    slv_sda_low <= 1'b1;
                    slv_rw      <= sh[0];
                end else phase <= 4;
            end
            if (phase == 1 && cnt == 8) begin
                cnt <= 0;
                if (slv_rw) begin
                    phase       <= 3;
                    slv_sda_low <= !io_out[7];
                end else begin
                    phase       <= 2;
                    slv_sda_low <= 1'b0;
                end
            end
            if (phase == 2 && cnt == 7) begin
                io_out      <= sh;
                slv_sda_low <= 1'b1;
            end
            if (phase == 2 && cnt == 8) begin
                phase       <= 4;
                slv_sda_low <= 1'b0;
            end
            if (phase == 2 && cnt == 2 && stretch_en) begin
                hold_cnt    <= 52 + 2 * DIV;
                slv_scl_low <= 1'b1;
            end
            if (phase == 3 && cnt >= 0 && cnt <= 6) slv_sda_low <= !io_out[6 - cnt];
            if (phase == 3 && cnt == 7) slv_sda_low <= 1'b0;
            if (phase == 3 && cnt == 8) phase <= 4;
        end
    end

    typedef struct {
        logic       nack;
        logic [7:0] rd;
        logic [7:0] io;
        int         dur;
        bit         stretch;
    } exp_t;
    exp_t sb[$];
    logic [7:0] m_io = 8'hFF, m_rd = 8'h00;
    int total = 0, bad = 0, acc = 0;

    // Push the expected outcome and issue one start; call just after a negedge.
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input bit str, input bit early);
        exp_t e;
        e.nack = (a != SLV);
        e.stretch = str;
        e.dur = e.nack ? 44 * DIV + 1 : 80 * DIV + 1;
        if (!e.nack && r) m_rd = m_io;
        if (!e.nack && !r) m_io = d;
        e.rd = m_rd;
        e.io = m_io;
        sb.push_back(e);
        rw = r; adr = a; wr_data = d; start = 1'b1;
        acc = early ? cyc + 1 : cyc;
        if (early) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dur);
        dur = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                dur = cyc - acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({rd_data, busy, done, nack_err, scl, sda} !== {8'h00, 3'b000, 2'b11}) begin
            bad++;
            $display("FAIL reset: got rd=%h b=%b d=%b n=%b scl=%b sda=%b", rd_data, busy, done, nack_err, scl, sda);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_nack;
        int dur, r0;
        exp_t e;
        r0 = n_rise;
        issue(1'b0, 7'h26, 8'h00, 1'b0, 1'b0);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || nack_err !== e.nack) begin
            bad++;
            $display("FAIL nack_write: got dur=%0d nack=%b want dur=%0d nack=%b", dur, nack_err, e.dur, e.nack);
        end
        total++;
        if (n_rise - r0 !== 10 || io_out !== e.io) begin
            bad++;
            $display("FAIL nack_bus: got rises=%0d io=%h want rises=10 io=%h", n_rise - r0, io_out, e.io);
        end
        @(negedge clk);
        issue(1'b1, 7'h26, 8'h00, 1'b0, 1'b0);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (nack_err !== e.nack || rd_data !== e.rd) begin
            bad++;
            $display("FAIL nack_read: got nack=%b rd=%h want nack=%b rd=%h", nack_err, rd_data, e.nack, e.rd);
        end
        @(negedge clk);
    endtask

    task automatic test_write;
        int dur, s0;
        exp_t e;
        s0 = n_start;
        issue(1'b0, SLV, 8'hA5, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL write_busy: got %b want 1", busy);
        end
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || nack_err !== e.nack) begin
            bad++;
            $display("FAIL write: got dur=%0d nack=%b want dur=%0d nack=%b", dur, nack_err, e.dur, e.nack);
        end
        total++;
        if (io_out !== e.io || n_start - s0 !== 1 || last_adr !== SLV) begin
            bad++;
            $display("FAIL write_bus: got io=%h starts=%0d adr=%h want io=%h starts=1 adr=%h", io_out, n_start - s0, last_adr, e.io, SLV);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_read;
        int dur, p0;
        exp_t e;
        p0 = n_stop;
        issue(1'b1, SLV, 8'h00, 1'b0, 1'b0);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || nack_err !== e.nack || rd_data !== e.rd) begin
            bad++;
            $display("FAIL read: got dur=%0d nack=%b rd=%h want dur=%0d nack=%b rd=%h", dur, nack_err, rd_data, e.dur, e.nack, e.rd);
        end
        total++;
        if (mack !== 1'b1 || n_stop - p0 !== 1) begin
            bad++;
            $display("FAIL read_bus: got master_ack=%b stops=%0d want 1 1", mack, n_stop - p0);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy;
        int dur, s0, extra;
        exp_t e;
        s0 = n_start;
        extra = 0;
        issue(1'b0, SLV, 8'h3C, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        adr = 7'h11; wr_data = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || io_out !== e.io || last_adr !== SLV || n_start - s0 !== 1) begin
            bad++;
            $display("FAIL ignore_busy: got dur=%0d io=%h adr=%h starts=%0d want %0d %h %h 1", dur, io_out, last_adr, n_start - s0, e.dur, e.io, SLV);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL single_done: got %0d extra pulses want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int dur;
        exp_t e;
        issue(1'b0, SLV, 8'hC3, 1'b0, 1'b0);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || io_out !== e.io) begin
            bad++;
            $display("FAIL b2b_first: got dur=%0d io=%h want %0d %h", dur, io_out, e.dur, e.io);
        end
        issue(1'b1, SLV, 8'h00, 1'b0, 1'b1);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || rd_data !== e.rd || nack_err !== e.nack) begin
            bad++;
            $display("FAIL b2b_second: got dur=%0d rd=%h nack=%b want %0d %h %b", dur, rd_data, nack_err, e.dur, e.rd, e.nack);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int seen, dur;
        exp_t e;
        seen = 0;
        rw = 1'b0; adr = SLV; wr_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40 * DIV + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({scl, sda, busy, done, rd_data} !== {2'b11, 2'b00, 8'h00}) begin
            bad++;
            $display("FAIL abort: got scl=%b sda=%b busy=%b done=%b rd=%h want 1 1 0 0 00", scl, sda, busy, done, rd_data);
        end
        reset = 1'b0;
        m_rd = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0 || io_out !== m_io) begin
            bad++;
            $display("FAIL abort_quiet: got activity=%0d io=%h want 0 %h", seen, io_out, m_io);
        end
        issue(1'b0, SLV, 8'hA5, 1'b0, 1'b0);
        wait_done(dur);
        e = sb.pop_front();
        total++;
        if (dur !== e.dur || io_out !== e.io || nack_err !== e.nack) begin
            bad++;
            $display("FAIL after_abort: got dur=%0d io=%h nack=%b want %0d %h %b", dur, io_out, nack_err, e.dur, e.io, e.nack);
        end
        @(negedge clk);
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch;
        int dur;
        exp_t e;
        stretch_en = 1'b1;
        issue(1'b0, SLV, 8'h96, 1'b1, 1'b0);
        wait_done(dur);
        stretch_en = 1'b0;
        e = sb.pop_front();
        total++;
        if (dur < e.dur + 50 || io_out !== e.io || nack_err !== e.nack) begin
            bad++;
            $display("FAIL stretch: got dur=%0d io=%h nack=%b want dur>=%0d io=%h nack=%b", dur, io_out, nack_err, e.dur + 50, e.io, e.nack);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_addr_nack;
        test_write;
        test_read;
        test_ignore_busy;
        test_back_to_back;
        test_reset_abort;
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch;
`endif
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
